dmx_ebr_read_arbiter: RTL

//  Shares the single read port (port B) of the DMX receive-frame EBR among NUM_REQ requesters.

---
 rtl/dmx_pkg.sv | 25 ++
 rtl/dmx_rr_picker.sv | 50 +++++
 rtl/dmx_ebr_read_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dmx_pkg.sv
// Shared constants and types for the DMX receive-frame EBR read path.
// No ports. Provides widths, default requester count, requester index
// assignments and the read-tag payload carried down the arbiter pipeline.
package dmx_pkg;

  localparam int unsigned DMX_ADDR_W      = 10;
  localparam int unsigned DMX_DATA_W      = 8;
  localparam int unsigned DMX_BUFFER_SIZE = 513;
  localparam int unsigned DMX_NUM_RD_REQ  = 3;

  // Requester index width covers up to 8 requesters.
  localparam int unsigned DMX_REQ_IDX_W   = 3;

  localparam int unsigned RQ_DMX_OUT      = 0;
  localparam int unsigned RQ_HOST         = 1;
  localparam int unsigned RQ_PATCH        = 2;

  // One in-flight read: valid, out-of-bounds flag, requester index.
  typedef struct packed {
    logic                     valid;
    logic                     oob;
    logic [DMX_REQ_IDX_W-1:0] idx;
  } dmx_rd_tag_t;

endpackage

// File: rtl/dmx_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   i_req   - request vector (already gated by the caller)
//   i_ptr   - round-robin pointer, highest priority index
//   o_gnt_c - one-hot grant
//   o_idx_c - binary index of the winner
//   o_any_c - at least one request present
module dmx_rr_picker
  import dmx_pkg::*;
#(
  parameter int unsigned NUM_REQ = DMX_NUM_RD_REQ
) (
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [DMX_REQ_IDX_W-1:0] i_ptr,
  output logic [NUM_REQ-1:0]       o_gnt_c,
  output logic [DMX_REQ_IDX_W-1:0] o_idx_c,
  output logic                     o_any_c
);

  localparam int unsigned IDX_W  = DMX_REQ_IDX_W;
  localparam int unsigned DIST_W = DMX_REQ_IDX_W + 1;

  logic [DIST_W-1:0] w_dist;
  logic [DIST_W-1:0] w_best_dist;

  // Winner is the requester with the smallest wrapped distance from the pointer.
  always_comb begin
    o_gnt_c     = '0;
    o_idx_c     = '0;
    o_any_c     = 1'b0;
    w_dist      = '0;
    w_best_dist = '1;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (IDX_W'(j) >= i_ptr) begin
        w_dist = DIST_W'(j) - DIST_W'(i_ptr);
      end else begin
        w_dist = DIST_W'(j) + DIST_W'(NUM_REQ) - DIST_W'(i_ptr);
      end
      if (i_req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        o_idx_c     = IDX_W'(j);
        o_any_c     = 1'b1;
      end
    end
    if (o_any_c) begin
      o_gnt_c = NUM_REQ'(1) << o_idx_c;
    end
  end

endmodule

// File: rtl/dmx_ebr_read_arbiter.sv
// Round-robin arbiter sharing EBR read port B among NUM_REQ requesters.
// One read issued per cycle; data returns on a shared rdata bus tagged by a
// per-requester one-cycle rvalid, RD_LATENCY+2 cycles after the grant.
// Optional feature macro: DMX_ARB_BOUNDS_CHECK_EN -- reads at or beyond
// last_byte_count (sampled at grant) return 0 instead of EBR data.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   rd_en           - global enable for new grants
//   req, addr       - per-requester request and packed read address
//   gnt             - combinational one-hot grant
//   rvalid, rdata   - registered read return
//   ebr_addr        - registered EBR AddressB
//   ebr_qb          - EBR QB read data
//   last_byte_count - valid length of the last received frame
module dmx_ebr_read_arbiter
  import dmx_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DMX_NUM_RD_REQ,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_W     = DMX_ADDR_W,
  parameter int unsigned DATA_W     = DMX_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ebr_addr,
  input  logic [DATA_W-1:0]         ebr_qb,
  input  logic [ADDR_W-1:0]         last_byte_count
);

  localparam int unsigned IDX_W     = DMX_REQ_IDX_W;
  localparam int unsigned TAG_DEPTH = 1 + RD_LATENCY;

  logic [NUM_REQ-1:0] w_req_gated;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic               w_oob;
  dmx_rd_tag_t        w_new_tag;

  logic [IDX_W-1:0]   r_ptr;
  dmx_rd_tag_t        r_tag [TAG_DEPTH];

  // rd_en off blocks new grants only; the tag pipeline keeps draining.
  assign w_req_gated = rd_en ? req : '0;

  dmx_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req   (w_req_gated),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_idx),
    .o_any_c (w_any)
  );

  assign gnt = w_gnt;

  // Address mux for the winning requester.
  always_comb begin
    w_sel_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_idx) begin
        w_sel_addr = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef DMX_ARB_BOUNDS_CHECK_EN
  assign w_oob = (w_sel_addr >= last_byte_count);
`else
  logic w_unused_lbc;
  assign w_unused_lbc = ^last_byte_count;
  assign w_oob        = 1'b0;
`endif

  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_any;
    w_new_tag.oob   = w_any & w_oob;
    w_new_tag.idx   = w_idx;
  end

  // Pointer moves past the winner; ebr_addr holds while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      ebr_addr <= '0;
    end else if (w_any) begin
      r_ptr    <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
      ebr_addr <= w_sel_addr;
    end
  end

  // Tag stage k is valid k+1 cycles after the grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_new_tag;
      for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Last tag stage lines up with ebr_qb for the same read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= r_tag[RD_LATENCY].valid ? (NUM_REQ'(1) << r_tag[RD_LATENCY].idx) : '0;
      if (r_tag[RD_LATENCY].valid) begin
        rdata <= r_tag[RD_LATENCY].oob ? '0 : ebr_qb;
      end
    end
  end

endmodule
